// File: rtl/lab61soc_pio_edge_capture_if.sv
// lab61soc_pio_edge_capture_if: Avalon-MM slave bus for the PIO edge-capture block
interface lab61soc_pio_edge_capture_if;
  logic [1:0] address;
  logic chipselect;
  logic write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master(output address, chipselect, write_n, writedata, input readdata);
  modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/lab61soc_pio_edge_capture.sv
// lab61soc_pio_edge_capture: synchronised PIO input with sticky edge capture and Avalon-MM access
// Define LAB61SOC_PIO_IRQ_EN to implement IRQMASK and a live irq; otherwise irq is tied low.
module lab61soc_pio_edge_capture #(
  parameter int WIDTH = 8,
  parameter int EDGE_TYPE = 0,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic reset_n,
  input logic [WIDTH-1:0] in_port,
  output logic irq,
  lab61soc_pio_edge_capture_if.slave bus
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
  logic [WIDTH-1:0] dly, cap, mask, det, clr, sel, data;
  logic wr;
  always_comb begin
    data = sync[SYNC_STAGES-1];
    wr = bus.chipselect & ~bus.write_n;
    clr = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
    det = EDGE_TYPE == 0 ? data & ~dly : EDGE_TYPE == 1 ? ~data & dly : data ^ dly;
    sel = bus.address == 2'd0 ? data : bus.address == 2'd1 ? mask : bus.address == 2'd3 ? cap : '0;
  end
  // det is ORed in after the clear so a same-cycle edge survives the write
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync <= '0;
      dly <= '0;
      cap <= '0;
      bus.readdata <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in_port};
      dly <= data;
      cap <= (cap & ~clr) | det;
      bus.readdata <= 32'(sel);
    end
`ifdef LAB61SOC_PIO_IRQ_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) mask <= '0;
    else if (wr && bus.address == 2'd1) mask <= bus.writedata[WIDTH-1:0];
  assign irq = |(cap & mask);
`else
  assign mask = '0;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_lab61soc_pio_edge_capture.sv
// tb_lab61soc_pio_edge_capture: rising/falling/any-edge instances driven together, checked against a sample-history model
module tb_lab61soc_pio_edge_capture;
  localparam int S = 2;
  logic clk = 0, reset_n = 0;
  logic [7:0] in_port = 0;
  logic [1:0] addr = 0;
  logic cs = 0, wn = 1;
  logic [31:0] wd = 0;
  logic [2:0] irq;
  logic [31:0] rd [3];
  int vec = 0, bad = 0;
  lab61soc_pio_edge_capture_if b0(), b1(), b2();
  assign {b0.address, b0.chipselect, b0.write_n, b0.writedata} = {addr, cs, wn, wd};
  assign {b1.address, b1.chipselect, b1.write_n, b1.writedata} = {addr, cs, wn, wd};
  assign {b2.address, b2.chipselect, b2.write_n, b2.writedata} = {addr, cs, wn, wd};
  assign rd[0] = b0.readdata;
  assign rd[1] = b1.readdata;
  assign rd[2] = b2.readdata;
  lab61soc_pio_edge_capture #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(S)) u0 (.clk(clk), .reset_n(reset_n), .in_port(in_port), .irq(irq[0]), .bus(b0));
  lab61soc_pio_edge_capture #(.WIDTH(8), .EDGE_TYPE(1), .SYNC_STAGES(S)) u1 (.clk(clk), .reset_n(reset_n), .in_port(in_port), .irq(irq[1]), .bus(b1));
  lab61soc_pio_edge_capture #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(S)) u2 (.clk(clk), .reset_n(reset_n), .in_port(in_port), .irq(irq[2]), .bus(b2));
  always #5 clk = ~clk;

  // h[j] is the in_port value sampled j+1 clock edges ago (zeros after reset)
  logic [7:0] h [4];
  logic [7:0] cap_m [3];
  logic [7:0] mask_m, ma, mb, mdet;
  logic [31:0] rd_m [3];
  logic [2:0] irq_m;
  assign irq_m = {|(cap_m[2] & mask_m), |(cap_m[1] & mask_m), |(cap_m[0] & mask_m)};
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) h[i] = 0;
      for (int k = 0; k < 3; k++) begin
        cap_m[k] = 0;
        rd_m[k] = 0;
      end
      mask_m = 0;
    end else begin
      ma = h[S-1];
      mb = h[S];
      for (int k = 0; k < 3; k++) begin
        mdet = k == 0 ? ma & ~mb : k == 1 ? ~ma & mb : ma ^ mb;
        rd_m[k] = addr == 0 ? {24'd0, ma} : addr == 1 ? {24'd0, mask_m} : addr == 3 ? {24'd0, cap_m[k]} : 32'd0;
        if (cs && !wn && addr == 3) cap_m[k] = cap_m[k] & ~wd[7:0];
        cap_m[k] = cap_m[k] | mdet;
      end
`ifdef LAB61SOC_PIO_IRQ_EN
      if (cs && !wn && addr == 1) mask_m = wd[7:0];
`endif
      for (int i = 3; i > 0; i--) h[i] = h[i-1];
      h[0] = in_port;
    end
  end

  task nclk;
    @(negedge clk);
  endtask
  task settle(input int n);
    repeat (n) nclk();
  endtask
  task bus_write(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    wd = d;
    cs = 1;
    wn = 0;
    nclk();
    cs = 0;
    wn = 1;
  endtask

  task test_reset;
    settle(2);
    for (int k = 0; k < 3; k++) begin
      vec++;
      if (rd[k] !== 32'h0 || irq[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset inst%0d readdata=%h irq=%b exp 0/0", k, rd[k], irq[k]);
      end
    end
    reset_n = 1;
    settle(3);
  endtask

  task test_data_path;
    logic [31:0] e;
    in_port = 8'h05;
    addr = 0;
    for (int n = 1; n <= 3; n++) begin
      nclk();
      e = n == 3 ? 32'h5 : 32'h0;
      vec++;
      if (rd[0] !== e) begin
        bad++;
        $display("FAIL data_path edge%0d readdata=%h exp=%h", n, rd[0], e);
      end
    end
    addr = 3;
    nclk();
    for (int k = 0; k < 3; k++) begin
      e = k == 1 ? 32'h0 : 32'h5;
      vec++;
      if (rd[k] !== e) begin
        bad++;
        $display("FAIL edgecap_rise inst%0d readdata=%h exp=%h", k, rd[k], e);
      end
    end
  endtask

  task test_clear_irq;
    in_port = 8'h01;
    settle(4);
    bus_write(3, 32'hFF);
`ifdef LAB61SOC_PIO_IRQ_EN
    bus_write(1, 32'h04);
`endif
    in_port = 8'h05;
    addr = 3;
    settle(4);
    vec++;
    if (rd[0] !== 32'h4) begin
      bad++;
      $display("FAIL clear_pre readdata=%h exp=%h", rd[0], 32'h4);
    end
`ifdef LAB61SOC_PIO_IRQ_EN
    vec++;
    if (irq[0] !== 1'b1) begin
      bad++;
      $display("FAIL irq_set irq=%b exp=1", irq[0]);
    end
`endif
    bus_write(3, 32'h04);
    vec++;
    if (irq[0] !== 1'b0 || irq[2] !== 1'b0) begin
      bad++;
      $display("FAIL irq_clear irq0=%b irq2=%b exp 0", irq[0], irq[2]);
    end
    nclk();
    vec++;
    if (rd[0] !== 32'h0) begin
      bad++;
      $display("FAIL clear_post readdata=%h exp=%h", rd[0], 32'h0);
    end
  endtask

  task test_set_wins;
    in_port = 8'h04;
    settle(4);
    bus_write(3, 32'hFF);
    in_port = 8'h05;
    addr = 3;
    settle(2);
    bus_write(3, 32'h01);
    nclk();
    vec++;
    if (rd[0] !== 32'h1 || rd[2] !== 32'h1) begin
      bad++;
      $display("FAIL set_wins inst0=%h inst2=%h exp 1/1", rd[0], rd[2]);
    end
    bus_write(3, 32'h01);
    nclk();
    vec++;
    if (rd[0] !== 32'h0) begin
      bad++;
      $display("FAIL w1c_only readdata=%h exp=%h", rd[0], 32'h0);
    end
  endtask

  task test_mask_and_ignored;
`ifdef LAB61SOC_PIO_IRQ_EN
    bus_write(1, 32'hA5);
    nclk();
    vec++;
    if (rd[0] !== 32'hA5) begin
      bad++;
      $display("FAIL irqmask_rw readdata=%h exp=%h", rd[0], 32'hA5);
    end
    bus_write(1, 32'h00);
`else
    in_port = 8'h04;
    settle(4);
    bus_write(3, 32'hFF);
    bus_write(1, 32'hFF);
    in_port = 8'h05;
    settle(4);
    vec++;
    if (rd[0] !== 32'h0 || irq[0] !== 1'b0) begin
      bad++;
      $display("FAIL no_mask readdata=%h irq=%b exp 0/0", rd[0], irq[0]);
    end
    addr = 3;
    nclk();
    vec++;
    if (rd[0] !== 32'h1) begin
      bad++;
      $display("FAIL no_mask_cap readdata=%h exp=%h", rd[0], 32'h1);
    end
`endif
    bus_write(2, 32'hFFFF_FFFF);
    nclk();
    vec++;
    if (rd[0] !== 32'h0) begin
      bad++;
      $display("FAIL reserved readdata=%h exp=%h", rd[0], 32'h0);
    end
    bus_write(0, 32'hFFFF_FFFF);
    nclk();
    vec++;
    if (rd[0] !== 32'h5) begin
      bad++;
      $display("FAIL data_ro readdata=%h exp=%h", rd[0], 32'h5);
    end
  endtask

  task test_falling;
    in_port = 8'hFF;
    settle(4);
    bus_write(3, 32'hFF);
    in_port = 8'hF0;
    addr = 3;
    settle(4);
    vec++;
    if (rd[1] !== 32'h0F) begin
      bad++;
      $display("FAIL falling readdata=%h exp=%h", rd[1], 32'h0F);
    end
    in_port = 8'hFF;
    settle(4);
    vec++;
    if (rd[1] !== 32'h0F) begin
      bad++;
      $display("FAIL falling_hold readdata=%h exp=%h", rd[1], 32'h0F);
    end
  endtask

  task test_reset_release;
    logic [31:0] e;
    in_port = 8'h01;
    reset_n = 0;
    settle(2);
    reset_n = 1;
    addr = 3;
    settle(5);
    for (int k = 0; k < 3; k++) begin
      e = k == 1 ? 32'h0 : 32'h1;
      vec++;
      if (rd[k] !== e) begin
        bad++;
        $display("FAIL reset_release inst%0d readdata=%h exp=%h", k, rd[k], e);
      end
    end
  endtask

  task test_reset_mid;
`ifdef LAB61SOC_PIO_IRQ_EN
    bus_write(1, 32'h01);
    vec++;
    if (irq[0] !== 1'b1) begin
      bad++;
      $display("FAIL irq_pre_reset irq=%b exp=1", irq[0]);
    end
`endif
    addr = 3;
    nclk();
    #2 reset_n = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      vec++;
      if (rd[k] !== 32'h0 || irq[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid inst%0d readdata=%h irq=%b exp 0/0", k, rd[k], irq[k]);
      end
    end
    nclk();
    reset_n = 1;
  endtask

  task test_random;
    for (int i = 0; i < 500; i++) begin
      nclk();
      for (int k = 0; k < 3; k++) begin
        vec++;
        if (rd[k] !== rd_m[k] || irq[k] !== irq_m[k]) begin
          bad++;
          $display("FAIL random cyc%0d inst%0d readdata=%h irq=%b exp %h/%b", i, k, rd[k], irq[k], rd_m[k], irq_m[k]);
        end
      end
      if ($urandom_range(3) == 0) in_port = 8'($urandom);
      addr = 2'($urandom);
      cs = 1'($urandom_range(1));
      wn = 1'($urandom_range(1));
      wd = $urandom;
    end
    cs = 0;
    wn = 1;
  endtask

  initial begin
    nclk();
    test_reset();
    test_data_path();
    test_clear_irq();
    test_set_wins();
    test_mask_and_ignored();
    test_falling();
    test_reset_release();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
